// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a fetch queue, and redirect handling that drops stale responses.
module fetch_unit #(
    parameter int                  ARCH_LEN  = 32,
    parameter int                  INST_LEN  = 32,
    parameter logic [ARCH_LEN-1:0] BOOT_ADDR = '0,
    parameter int                  FQ_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    output logic [ARCH_LEN-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ARCH_LEN-1:0] redirect_pc,
    input  logic                stall_in,
    output logic                inst_valid_out,
    output logic [INST_LEN-1:0] inst_out,
    output logic [ARCH_LEN-1:0] inst_pc_out,
    output logic [1:0]          dbg_state
);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // a response is consumed on every cycle imem_rsp_valid is high (no back-pressure);
    // the queue head transfers to decode when inst_valid_out && !stall_in.

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [INST_LEN-1:0] NOP     = INST_LEN'(32'h0000_0013);

    state_t              state;
    logic [ARCH_LEN-1:0] fetch_pc;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    drop_cnt;
    logic [CNT_W-1:0]    q_cnt;
    logic [PTR_W-1:0]    q_rd;
    logic [PTR_W-1:0]    q_wr;
    logic [PTR_W-1:0]    rp_rd;
    logic [PTR_W-1:0]    rp_wr;
    logic [INST_LEN-1:0] inst_q [FQ_DEPTH];
    logic [ARCH_LEN-1:0] pc_q   [FQ_DEPTH];
    logic [ARCH_LEN-1:0] rp_q   [FQ_DEPTH];

    logic                issue;
    logic                push;
    logic                pop;
    logic                dropping;
    logic [CNT_W-1:0]    out_after;
    logic [CNT_W:0]      credit_used;

    // Queue entries plus in-flight requests never exceed the queue depth, so a
    // response always has a slot even when decode is stalled.
    assign credit_used    = {1'b0, q_cnt} + {1'b0, outstanding};
    assign imem_req_valid = (state == RUN) && !redirect_valid &&
                            (credit_used < {1'b0, DEPTH_C});
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    assign out_after = outstanding - CNT_W'(imem_rsp_valid);
    assign dropping  = (drop_cnt != '0);
    assign push      = imem_rsp_valid && !redirect_valid && !dropping;
    assign pop       = inst_valid_out && !stall_in && !redirect_valid;

    assign inst_valid_out = (q_cnt != '0);
    assign inst_out       = inst_valid_out ? inst_q[q_rd] : NOP;
    assign inst_pc_out    = inst_valid_out ? pc_q[q_rd] : '0;
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= BOOT_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            rp_rd       <= '0;
            rp_wr       <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rsp_valid);

            // Request-PC FIFO tracks every in-flight request, dropped or not,
            // so it is never flushed by a redirect.
            if (issue) begin
                rp_q[rp_wr] <= fetch_pc;
                rp_wr       <= rp_wr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                rp_rd <= rp_rd + PTR_W'(1);
            end

            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ARCH_LEN-1:2], 2'b00};
                q_cnt    <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
                drop_cnt <= out_after;
                state    <= (out_after != '0) ? DRAIN : RUN;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ARCH_LEN'(4);
                end
                if (push) begin
                    inst_q[q_wr] <= imem_rsp_data;
                    pc_q[q_wr]   <= rp_q[rp_rd];
                    q_wr         <= q_wr + PTR_W'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PTR_W'(1);
                end
                q_cnt <= q_cnt + CNT_W'(push) - CNT_W'(pop);
                if (imem_rsp_valid && dropping) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                case (state)
                    BOOT:    state <= RUN;
                    DRAIN:   if (imem_rsp_valid && drop_cnt == CNT_W'(1)) state <= RUN;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ARCH_LEN, default 32, address/PC width.
REQ-002 SHALL have parameter INST_LEN, default 32, instruction width.
REQ-003 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, PC loaded on reset.
REQ-004 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-008 SHALL have port imem_req_addr, output, ARCH_LEN, fetch address.
REQ-009 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-010 SHALL have port imem_rsp_valid, input, 1, response data valid.
REQ-011 SHALL have port imem_rsp_data, input, INST_LEN, fetched instruction.
REQ-012 SHALL have port redirect_valid, input, 1, branch/exception redirect.
REQ-013 SHALL have port redirect_pc, input, ARCH_LEN, redirect target.
REQ-014 SHALL have port stall_in, input, 1, decode cannot accept this cycle.
REQ-015 SHALL have port inst_valid_out, output, 1, queue head valid.
REQ-016 SHALL have port inst_out, output, INST_LEN, queue head instruction.
REQ-017 SHALL have port inst_pc_out, output, ARCH_LEN, PC of queue head.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, DRAIN; BOOT -> RUN after exactly one cycle; RUN -> DRAIN on redirect with outstanding>0 (excluding responses arriving that cycle); DRAIN -> RUN when drop count reaches 0.
REQ-019 SHALL drive imem_req_valid=1 only in RUN, with no redirect_valid this cycle, and (queue count + outstanding) < FQ_DEPTH.
REQ-020 SHALL drive imem_req_addr = fetch_pc; a request is issued when imem_req_valid && imem_req_ready.
REQ-021 SHALL advance fetch_pc by 4 per issued request, wrapping modulo 2^ARCH_LEN; fetch_pc held otherwise.
REQ-022 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
REQ-023 SHALL accept in-order responses, latency >=1 cycle; outstanding counter +1 per issue, -1 per response, range 0..FQ_DEPTH.
REQ-024 SHALL push each non-dropped response into the queue with the PC of its request (request-PC FIFO, same depth).
REQ-025 SHALL present queue head on inst_out/inst_pc_out with inst_valid_out=1 whenever non-empty; pop when inst_valid_out && !stall_in.
REQ-026 SHALL drive inst_out=32'h0000_0013 (NOP), inst_pc_out=0, inst_valid_out=0 when queue empty.
REQ-027 SHALL support push and pop in the same cycle, including when full; credit rule in REQ-019 guarantees no overflow.
REQ-028 SHALL on redirect_valid: flush queue, load fetch_pc = {redirect_pc[ARCH_LEN-1:2],2'b00}, set drop count = outstanding after this cycle's response; redirect takes priority over stall_in, pop, push and issue.
REQ-029 SHALL discard a response arriving in the redirect cycle and all responses while drop count>0, decrementing drop count per discarded response.
REQ-030 SHALL accept a second redirect in DRAIN: reload fetch_pc, keep drop count accumulation consistent with outstanding.
REQ-031 SHALL issue no requests in DRAIN or BOOT.

Reset
REQ-032 SHALL on rst: fetch_pc=BOOT_ADDR, state=BOOT, queue empty, outstanding=0, drop count=0; imem_req_valid=0, inst_valid_out=0, inst_out=NOP, inst_pc_out=0 next cycle.
REQ-033 SHALL let rst override redirect_valid and in-flight responses; responses to pre-reset requests are the environment's responsibility to suppress.

Verification
REQ-034 Reset, ready=1, 1-cycle rsp, no stall -> first req addr 0x0 two cycles after rst release; inst_pc_out sequence 0x0,0x4,0x8.
REQ-035 stall_in=1 held 10 cycles -> exactly FQ_DEPTH requests issued, inst_valid_out=1, head stays PC 0x0; release -> in-order drain.
REQ-036 redirect_pc=0x103 with 2 outstanding -> queue flushed, DRAIN, 2 responses dropped, next req addr 0x100, first output PC 0x100.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_req_addr constant, fetch_pc unchanged, no queue push.
REQ-038 redirect same cycle as response and stall_in=1 -> response dropped, queue empty next cycle, fetch_pc=target.
REQ-039 BOOT_ADDR=32'hFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
